// File: rtl/spi_sequencer.sv
// spi_sequencer: queues 32-bit SPI commands, runs them one at a time on an
// SPI controller and queues the returned words in command order.
// Ports: CLK, RESET (sync, active-high); CMD_* command push (valid/ready);
// RSP_* response pop (valid/ready); SPI_* controller kick/busy/dout;
// SEQ_IDLE status; TIMEOUT_ERR sticky wait-timeout flag.
// Build option: define SPI_SEQ_TIMEOUT_EN to bound every wait state to
// TIMEOUT_CYCLES cycles; without it the waits are unbounded.

module spi_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_DATA,
    input  logic        CMD_NORESP,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        SPI_KICK,
    output logic [31:0] SPI_DIN,
    input  logic        SPI_BUSY,
    input  logic [31:0] SPI_DOUT,
    input  logic        SPI_DOUT_VALID,
    output logic        SEQ_IDLE,
    output logic        TIMEOUT_ERR
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        WAIT_IDLE
    } state_t;

    state_t      state_q;
    logic        kick_q;
    logic [31:0] din_q;
    // Set while the running command owes the response FIFO one entry.
    logic        rsv_q;

    // ---------------- command FIFO ----------------
    logic [31:0]  cmd_data_mem [CMD_DEPTH];
    logic         cmd_nr_mem   [CMD_DEPTH];
    logic [CAW:0] cmd_wr_q, cmd_wr_d;
    logic [CAW:0] cmd_rd_q, cmd_rd_d;
    logic         cmd_empty, cmd_full;
    logic         cmd_push, cmd_pop;
    logic [31:0]  cmd_head_data;
    logic         cmd_head_nr;

    assign cmd_empty = (cmd_wr_q == cmd_rd_q);
    assign cmd_full  = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                       (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
    assign CMD_READY = !cmd_full && !RESET;
    assign cmd_push  = CMD_VALID && CMD_READY;
    assign cmd_wr_d  = cmd_wr_q + (CAW+1)'(cmd_push);
    assign cmd_rd_d  = cmd_rd_q + (CAW+1)'(cmd_pop);

    assign cmd_head_data = cmd_data_mem[cmd_rd_q[CAW-1:0]];
    assign cmd_head_nr   = cmd_nr_mem[cmd_rd_q[CAW-1:0]];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_wr_q <= '0;
            cmd_rd_q <= '0;
        end else begin
            cmd_wr_q <= cmd_wr_d;
            cmd_rd_q <= cmd_rd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (cmd_push) begin
            cmd_data_mem[cmd_wr_q[CAW-1:0]] <= CMD_DATA;
            cmd_nr_mem[cmd_wr_q[CAW-1:0]]   <= CMD_NORESP;
        end
    end

    // ---------------- response FIFO ----------------
    logic [31:0]  rsp_data_mem [RSP_DEPTH];
    logic         rsp_err_mem  [RSP_DEPTH];
    logic [RAW:0] rsp_wr_q, rsp_wr_d;
    logic [RAW:0] rsp_rd_q, rsp_rd_d;
    logic [RAW:0] rsp_used;
    logic         rsp_empty, rsp_room;
    logic         rsp_push, rsp_pop;
    logic [31:0]  rsp_push_data;
    logic         rsp_push_err;

    assign rsp_empty = (rsp_wr_q == rsp_rd_q);
    // Occupancy plus the slot promised to the command in flight.
    assign rsp_used  = (rsp_wr_q - rsp_rd_q) + (RAW+1)'(rsv_q);
    assign rsp_room  = rsp_used < (RAW+1)'(RSP_DEPTH);
    assign RSP_VALID = !rsp_empty;
    assign rsp_pop   = RSP_VALID && RSP_READY;
    assign rsp_wr_d  = rsp_wr_q + (RAW+1)'(rsp_push);
    assign rsp_rd_d  = rsp_rd_q + (RAW+1)'(rsp_pop);

    assign RSP_DATA = RSP_VALID ? rsp_data_mem[rsp_rd_q[RAW-1:0]] : '0;
    assign RSP_ERR  = RSP_VALID ? rsp_err_mem[rsp_rd_q[RAW-1:0]] : 1'b0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_wr_q <= '0;
            rsp_rd_q <= '0;
        end else begin
            rsp_wr_q <= rsp_wr_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (rsp_push) begin
            rsp_data_mem[rsp_wr_q[RAW-1:0]] <= rsp_push_data;
            rsp_err_mem[rsp_wr_q[RAW-1:0]]  <= rsp_push_err;
        end
    end

    // ---------------- sequencing ----------------
    logic start;
    logic adv;
    logic tmo_hit;

    assign start = (state_q == IDLE) && !cmd_empty && !SPI_BUSY &&
                   (cmd_head_nr || rsp_room);
    assign cmd_pop = start;

    // Wait state is about to leave through its normal exit.
    assign adv = ((state_q == WAIT_BUSY) && SPI_BUSY) ||
                 ((state_q == WAIT_DONE) && SPI_DOUT_VALID) ||
                 ((state_q == WAIT_IDLE) && !SPI_BUSY);

    // A timeout only pushes the error word if the real word never arrived.
    assign rsp_push = rsv_q &&
                      (((state_q == WAIT_DONE) && SPI_DOUT_VALID) || tmo_hit);
    assign rsp_push_data = tmo_hit ? 32'hFFFF_FFFF : SPI_DOUT;
    assign rsp_push_err  = tmo_hit;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q;
    logic          in_wait;

    assign in_wait = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE) ||
                     (state_q == WAIT_IDLE);
    assign tmo_hit = in_wait && !adv &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    // Cleared on every entry into a wait state.
    assign tmo_cnt_d = ((state_q == KICK) || adv) ? '0 :
                       tmo_cnt_q + TW'(in_wait);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit)
                tmo_err_q <= 1'b1;
        end
    end

    assign TIMEOUT_ERR = tmo_err_q;
`else
    logic unused_tmo;

    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign tmo_hit     = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            kick_q  <= 1'b0;
            din_q   <= '0;
            rsv_q   <= 1'b0;
        end else begin
            kick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= KICK;
                        kick_q  <= 1'b1;
                        din_q   <= cmd_head_data;
                        rsv_q   <= !cmd_head_nr;
                    end
                end
                KICK: state_q <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (SPI_BUSY) begin
                        state_q <= WAIT_DONE;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                        rsv_q   <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (SPI_DOUT_VALID) begin
                        state_q <= WAIT_IDLE;
                        rsv_q   <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                        rsv_q   <= 1'b0;
                    end
                end
                WAIT_IDLE: begin
                    if (!SPI_BUSY || tmo_hit)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SPI_KICK = kick_q;
    assign SPI_DIN  = din_q;
    assign SEQ_IDLE = (state_q == IDLE) && cmd_empty;

endmodule

// File: tb/tb_spi_sequencer.sv
// tb_spi_sequencer: randomized bench for spi_sequencer with a behavioural
// SPI controller model and command/response scoreboards.
`timescale 1ns/1ps

module tb_spi_sequencer;
    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [31:0] CMD_DATA = '0;
    logic        CMD_NORESP = 1'b0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic        SPI_KICK;
    logic [31:0] SPI_DIN;
    logic        SPI_BUSY = 1'b0;
    logic [31:0] SPI_DOUT = '0;
    logic        SPI_DOUT_VALID = 1'b0;
    logic        SEQ_IDLE;
    logic        TIMEOUT_ERR;

    always #5 CLK = ~CLK;

    spi_sequencer #(
        .CMD_DEPTH(4),
        .RSP_DEPTH(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_DATA(CMD_DATA),
        .CMD_NORESP(CMD_NORESP),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR),
        .SPI_KICK(SPI_KICK),
        .SPI_DIN(SPI_DIN),
        .SPI_BUSY(SPI_BUSY),
        .SPI_DOUT(SPI_DOUT),
        .SPI_DOUT_VALID(SPI_DOUT_VALID),
        .SEQ_IDLE(SEQ_IDLE),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_cmd[$];
    rsp_t        exp_rsp[$];

    int   kicks = 0;
    int   rsps = 0;
    int   cyc = 0;
    int   last_kick_cyc = -100;
    logic [31:0] last_din = '0;
    int   rr_mode = 1;
    logic silent = 1'b0;
    logic slow = 1'b0;
    int   m_ph = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // The word the controller model returns for a given command.
    function automatic logic [31:0] spi_fn(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]} ^ 32'h0000_00FF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic nr);
        logic ok;
        rsp_t r;
        ok = 1'b0;
        CMD_VALID = 1'b1;
        CMD_DATA = d;
        CMD_NORESP = nr;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge CLK);
            ok = CMD_READY;
            @(posedge CLK);
        end
        chk("push_done", 32'(ok), 1);
        if (ok) begin
            exp_cmd.push_back(d);
            if (!nr) begin
                r.d = silent ? 32'hFFFF_FFFF : spi_fn(d);
                r.e = silent;
                exp_rsp.push_back(r);
            end
        end
        #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick(1);
            ok = (exp_cmd.size() == 0) && (exp_rsp.size() == 0) &&
                 SEQ_IDLE && !SPI_BUSY && (m_ph == 0);
        end
        chk(tag, 32'(ok), 1);
    endtask

    // SPI controller model: busy after a kick, one DOUT_VALID pulse,
    // then an occasional stray DOUT_VALID before busy drops.
    initial begin
        int cnt;
        logic [31:0] din;
        logic junk;
        cnt = 0;
        din = '0;
        junk = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            SPI_DOUT_VALID = 1'b0;
            if (RESET) begin
                m_ph = 0;
                SPI_BUSY = 1'b0;
            end else begin
                case (m_ph)
                    0: if (SPI_KICK && !silent) begin
                        din = SPI_DIN;
                        cnt = $urandom_range(0, 2);
                        m_ph = 1;
                    end
                    1: if (cnt == 0) begin
                        SPI_BUSY = 1'b1;
                        cnt = slow ? 10 : $urandom_range(0, 3);
                        m_ph = 2;
                    end else cnt--;
                    2: if (cnt == 0) begin
                        SPI_DOUT_VALID = 1'b1;
                        SPI_DOUT = spi_fn(din);
                        cnt = $urandom_range(1, 3);
                        junk = 1'($urandom_range(0, 1));
                        m_ph = 3;
                    end else cnt--;
                    3: begin
                        if (junk && cnt == 1) begin
                            SPI_DOUT_VALID = 1'b1;
                            SPI_DOUT = 32'hDEAD_BEEF;
                        end
                        if (cnt == 0) begin
                            SPI_BUSY = 1'b0;
                            m_ph = 0;
                        end else cnt--;
                    end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rr_mode)
                0: RSP_READY = 1'b0;
                1: RSP_READY = 1'b1;
                default: RSP_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Kick monitor: order, spacing and hold of SPI_DIN.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (RESET) begin
                last_din = '0;
            end else if (SPI_KICK) begin
                kicks++;
                chk("kick_gap", 32'((cyc - last_kick_cyc) >= 4), 1);
                chk("kick_queued", 32'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0)
                    chk("kick_din", SPI_DIN, exp_cmd.pop_front());
                last_kick_cyc = cyc;
                last_din = SPI_DIN;
            end else if (cyc % 8 == 0) begin
                chk("din_hold", SPI_DIN, last_din);
            end
        end
    end

    // Response monitor: order, contents and stability while stalled.
    initial begin
        rsp_t e;
        logic held_v;
        logic [31:0] held_d;
        held_v = 1'b0;
        held_d = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                held_v = 1'b0;
            end else if (RSP_VALID && RSP_READY) begin
                rsps++;
                chk("rsp_queued", 32'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    e = exp_rsp.pop_front();
                    chk("rsp_data", RSP_DATA, e.d);
                    chk("rsp_err", 32'(RSP_ERR), 32'(e.e));
                end
                held_v = 1'b0;
            end else if (RSP_VALID) begin
                if (held_v)
                    chk("rsp_hold", RSP_DATA, held_d);
                held_v = 1'b1;
                held_d = RSP_DATA;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0;
        int r0;
        int nresp;
        int n;
        logic nr;
        logic ok;

        tick(3);
        chk("rst_cmd_ready", 32'(CMD_READY), 0);
        chk("rst_kick", 32'(SPI_KICK), 0);
        chk("rst_din", SPI_DIN, 0);
        RESET = 1'b0;
        #1;
        chk("post_rst_ready", 32'(CMD_READY), 1);
        tick(1);
        chk("idle_seq", 32'(SEQ_IDLE), 1);
        chk("idle_rsp_valid", 32'(RSP_VALID), 0);
        chk("idle_rsp_data", RSP_DATA, 0);
        chk("idle_rsp_err", 32'(RSP_ERR), 0);
        chk("idle_tmo", 32'(TIMEOUT_ERR), 0);

        // Single command.
        k0 = kicks;
        r0 = rsps;
        push(32'hA500_0000, 1'b0);
        wait_drain("t1_drain");
        chk("t1_kicks", 32'(kicks - k0), 1);
        chk("t1_rsps", 32'(rsps - r0), 1);

        // Response FIFO back-pressure.
        rr_mode = 0;
        tick(2);
        k0 = kicks;
        r0 = rsps;
        for (int i = 0; i < 6; i++)
            push(32'($urandom), 1'b0);
        tick(100);
        chk("t2_kicks_stall", 32'(kicks - k0), 4);
        chk("t2_rsps_stall", 32'(rsps - r0), 0);
        chk("t2_valid", 32'(RSP_VALID), 1);
        rr_mode = 1;
        wait_drain("t2_drain");
        chk("t2_kicks", 32'(kicks - k0), 6);
        chk("t2_rsps", 32'(rsps - r0), 6);

        // No-response command in the middle.
        k0 = kicks;
        r0 = rsps;
        push(32'h1111_0001, 1'b0);
        push(32'h2222_0002, 1'b1);
        push(32'h3333_0003, 1'b0);
        wait_drain("t3_drain");
        chk("t3_kicks", 32'(kicks - k0), 3);
        chk("t3_rsps", 32'(rsps - r0), 2);

        // Random traffic.
        rr_mode = 2;
        k0 = kicks;
        r0 = rsps;
        nresp = 0;
        for (int i = 0; i < 40; i++) begin
            nr = ($urandom_range(0, 3) == 0);
            if (!nr)
                nresp++;
            push(32'($urandom), nr);
            tick($urandom_range(0, 3));
        end
        wait_drain("t4_drain");
        chk("t4_kicks", 32'(kicks - k0), 40);
        chk("t4_rsps", 32'(rsps - r0), 32'(nresp));
        rr_mode = 1;

`ifdef SPI_SEQ_TIMEOUT_EN
        // Controller never answers: the wait times out.
        silent = 1'b1;
        k0 = kicks;
        push(32'h1234_5678, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge CLK);
            #2;
            ok = (kicks != k0);
        end
        chk("tmo_kick", 32'(ok), 1);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge CLK);
            #2;
            n++;
            ok = TIMEOUT_ERR;
        end
        chk("tmo_seen", 32'(ok), 1);
        chk("tmo_lat", 32'(n inside {[16:17]}), 1);
        silent = 1'b0;
        wait_drain("tmo_drain");
        push(32'h0BAD_F00D, 1'b0);
        wait_drain("tmo_after_drain");
        chk("tmo_sticky", 32'(TIMEOUT_ERR), 1);
`else
        n = 0;
`endif

        // Reset in the middle of a transaction with commands queued.
        slow = 1'b1;
        k0 = kicks;
        push(32'hC0DE_0001, 1'b0);
        push(32'hC0DE_0002, 1'b0);
        push(32'hC0DE_0003, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick(1);
            ok = SPI_BUSY;
        end
        chk("t5_busy", 32'(ok), 1);
        tick(2);
        chk("t5_one_kick", 32'(kicks - k0), 1);
        RESET = 1'b1;
        tick(2);
        chk("t5_rst_ready", 32'(CMD_READY), 0);
        exp_cmd.delete();
        exp_rsp.delete();
        slow = 1'b0;
        RESET = 1'b0;
        tick(1);
        chk("t5_seq_idle", 32'(SEQ_IDLE), 1);
        chk("t5_rsp_valid", 32'(RSP_VALID), 0);
        chk("t5_tmo", 32'(TIMEOUT_ERR), 0);
        k0 = kicks;
        tick(40);
        chk("t5_no_kick", 32'(kicks - k0), 0);
        chk("t5_rsp_valid2", 32'(RSP_VALID), 0);
        chk("t5_seq_idle2", 32'(SEQ_IDLE), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
